// File: rtl/shift_ser_pkg.sv
// Shared types and helpers for the parallel-load serial shifter controller.
package shift_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // A requested length of 0 or anything above the word width means a full word.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/shift_ser_dp.sv
// Load/shift register and remaining-bit counter for the serial shifter.
module shift_ser_dp
    import shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_W     = $clog2(WIDTH + 1),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_din,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_bit,
    output logic [CNT_W-1:0] o_cnt
);

    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;

    // Clear beats load beats shift; the count never decrements below zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_din;
            r_cnt <= i_len;
        end else if (i_shift && (r_cnt != '0)) begin
            r_sh  <= MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_bit = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
    assign o_cnt = r_cnt;

endmodule

// File: rtl/shift_ser_ctrl.sv
// Serial shifter sequencer: word handshake, bit framing, inter-word gap and done pulse.
module shift_ser_ctrl
    import shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = $clog2(WIDTH + 1),
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_valid_i,
    output logic             din_ready_o,
    input  logic [CNT_W-1:0] len_i,
    input  logic             shift_en_i,
    input  logic             abort_i,
    output logic             dout_o,
    output logic             frame_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_e           r_state;
    state_e           w_next;
    logic [GAP_W-1:0] r_gap;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_len;
    logic             w_bit;
    logic             w_accept;
    logic             w_last;
    logic             w_gap_end;
    logic             w_load;
    logic             w_shift;
    logic             w_clear;

    assign w_accept  = din_valid_i && (r_state == IDLE) && !abort_i;
    assign w_last    = (r_state == SHIFT) && (w_cnt == CNT_W'(1)) && shift_en_i && !abort_i;
    assign w_gap_end = (r_state == GAP) && shift_en_i && (r_gap == GAP_W'(GAP_LAST));
    assign w_len     = CNT_W'(eff_len(32'(len_i), WIDTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort dominates every other transition out of SHIFT and GAP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = SHIFT;
            end
            SHIFT: begin
                if (abort_i)     w_next = IDLE;
                else if (w_last) w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (abort_i || w_gap_end) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        din_ready_o = 1'b0;
        frame_o     = 1'b0;
        busy_o      = 1'b0;
        dout_o      = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        din_ready_o = (r_state == IDLE) && !abort_i;
        frame_o     = (r_state == SHIFT);
        busy_o      = (r_state != IDLE);
        dout_o      = (r_state == SHIFT) && w_bit;
        w_load      = w_accept;
        w_shift     = (r_state == SHIFT) && shift_en_i;
        w_clear     = abort_i && (r_state != IDLE);
    end

    // Gap strobe counter, held at zero outside GAP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gap <= '0;
        end else if ((r_state != GAP) || abort_i) begin
            r_gap <= '0;
        end else if (shift_en_i) begin
            r_gap <= w_gap_end ? '0 : r_gap + GAP_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
        end
    end

    assign done_o = r_done;

    shift_ser_dp #(
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_dp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_load),
        .i_shift(w_shift),
        .i_clear(w_clear),
        .i_din  (din_i),
        .i_len  (w_len),
        .o_bit  (w_bit),
        .o_cnt  (w_cnt)
    );

endmodule
